arbiter_bus_mux: RTL and testbench
==================================

// Module: arbiter_bus_mux
// PURPOSE
//  Downstream stage of the sticky-grant priority arbiter. Takes its one-hot grant vector and
//  routes the granted requester's single-beat transaction to one shared target. The
//  transaction is locked to the latched requester until the target responds or a timeout
//  expires. A one-cycle done (and error) pulse goes back to the owning requester only.
// PARAMETERS
//  Count         3    number of requesters; width of grant_i and the per-requester vectors
//  AddrWidth     32   address width
//  DataWidth     32   read/write data width
//  TimeoutCycles 255  max WAIT cycles before error completion; >=1
// PORTS
//  clk_i            in   1                  clock, all logic on posedge
//  rst_ni           in   1                  reset: synchronous, active-low
//  grant_i          in   Count              one-hot grant from the arbiter (all-zero = none)
//  req_valid_i      in   Count              requester k has a transaction pending
//  req_we_i         in   Count              1 = write, 0 = read
//  req_addr_i       in   Count*AddrWidth    packed; slice k = [k*AddrWidth +: AddrWidth]
//  req_wdata_i      in   Count*DataWidth    packed like req_addr_i
//  req_done_o       out  Count              one-cycle completion pulse to the owner only
//  req_err_o        out  Count              high with req_done_o on timeout
//  req_rdata_o      out  DataWidth          read data; valid while any req_done_o is high
//  tgt_valid_o      out  1                  request to the target
//  tgt_ready_i      in   1                  target accepts request when tgt_valid_o & tgt_ready_i
//  tgt_we_o         out  1                  registered copy of the owner's we
//  tgt_addr_o       out  AddrWidth          registered copy of the owner's address
//  tgt_wdata_o      out  DataWidth          registered copy of the owner's write data
//  tgt_rsp_valid_i  in   1                  target response strobe (reads and writes)
//  tgt_rdata_i      in   DataWidth          response data, sampled with tgt_rsp_valid_i
//  protocol_err_o   out  1                  sticky; cleared only by reset
// BEHAVIOUR
//  Reset (rst_ni=0 at posedge)
//   - state=IDLE; every output and the timeout counter go to 0.
//   - An in-flight transaction is dropped. No done pulse. The target is reset alongside.
//  FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE
//   - IDLE: if grant_i is one-hot with bit k, and req_valid_i[k]=1:
//       latch owner=k; register we/addr/wdata of slice k; go to ISSUE.
//       If grant_i is non-zero and not one-hot: stay in IDLE, set protocol_err_o.
//   - ISSUE: tgt_valid_o=1, tgt_* outputs held stable.
//       On tgt_valid_o & tgt_ready_i: go to WAIT and clear the counter.
//   - WAIT: tgt_valid_o=0.
//       tgt_rsp_valid_i=1: capture tgt_rdata_i, go to RESP with err=0.
//       Otherwise the counter increments. When counter==TimeoutCycles-1 with no response:
//       go to RESP with err=1 and rdata=0.
//       Response and timeout in the same cycle: the response wins.
//   - RESP (exactly 1 cycle): req_done_o[owner]=1, req_err_o[owner]=err, req_rdata_o=captured
//       data. Next state is IDLE; req_done_o/req_err_o/req_rdata_o return to 0.
//  Latency
//   - grant+valid seen in cycle N -> tgt_valid_o high in N+1.
//   - Response sampled in cycle M -> done pulse in M+1.
//   - Minimum turnaround: 4 cycles from acceptance to the next possible issue.
//  Rules
//   - Grant changes or req_valid_i drops after the latch are ignored; the owner is fixed until RESP.
//   - Requesters drop valid the cycle after seeing done.
//     While in IDLE, a still-high valid re-issues (the arbiter keeps the grant).
//   - tgt_rsp_valid_i outside WAIT: ignored and sets protocol_err_o.
//   - Never more than one outstanding target transaction.
//   - Counter width: $clog2(TimeoutCycles+1).
// TESTING
//  1. grant_i=001, req_valid_i=001, read addr 0x10; tgt_ready_i=1; rsp 2 cycles later with rdata 0xCAFE
//     -> tgt_valid_o one cycle; req_done_o=001, req_rdata_o=0xCAFE, req_err_o=000.
//  2. Owner 1 writes addr 0x20 data 0x55; tgt_ready_i low 3 cycles
//     -> tgt_valid_o/addr/wdata held stable 4 cycles; done=010 after the response.
//  3. No response, TimeoutCycles=4
//     -> 4 WAIT cycles, then req_done_o=req_err_o=100, req_rdata_o=0.
//     Response on the 4th WAIT cycle -> err=0.
//  4. grant_i switches 010->001 during WAIT -> done still goes to 010; 001 is issued afterwards.
//  5. grant_i=011 in IDLE, or tgt_rsp_valid_i in IDLE -> no issue, protocol_err_o=1 until reset.
//  6. rst_ni=0 during WAIT -> next cycle all outputs 0, no done pulse; a fresh request issues normally.

Source files
------------

// File: rtl/arbiter_bus_mux.sv
// arbiter_bus_mux: routes the granted requester's single-beat
// transaction to one shared target and pulses done/err back to it.
module arbiter_bus_mux #(
    parameter int Count         = 3,
    parameter int AddrWidth     = 32,
    parameter int DataWidth     = 32,
    parameter int TimeoutCycles = 255
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [Count-1:0]           grant_i,
    input  logic [Count-1:0]           req_valid_i,
    input  logic [Count-1:0]           req_we_i,
    input  logic [Count*AddrWidth-1:0] req_addr_i,
    input  logic [Count*DataWidth-1:0] req_wdata_i,
    output logic [Count-1:0]           req_done_o,
    output logic [Count-1:0]           req_err_o,
    output logic [DataWidth-1:0]       req_rdata_o,
    output logic                       tgt_valid_o,
    input  logic                       tgt_ready_i,
    output logic                       tgt_we_o,
    output logic [AddrWidth-1:0]       tgt_addr_o,
    output logic [DataWidth-1:0]       tgt_wdata_o,
    input  logic                       tgt_rsp_valid_i,
    input  logic [DataWidth-1:0]       tgt_rdata_i,
    output logic                       protocol_err_o
);

    localparam int CntW = $clog2(TimeoutCycles + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_e;

    state_e                 state_q, state_d;
    logic [Count-1:0]       owner_q, owner_d;
    logic                   we_q, we_d;
    logic [AddrWidth-1:0]   addr_q, addr_d;
    logic [DataWidth-1:0]   wdata_q, wdata_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   err_q, err_d;
    logic [DataWidth-1:0]   rdata_q, rdata_d;
    logic                   perr_q, perr_d;

    logic                   grant_any;
    logic                   grant_one;
    logic                   sel_valid;
    logic                   sel_we;
    logic [AddrWidth-1:0]   sel_addr;
    logic [DataWidth-1:0]   sel_wdata;

    assign grant_any = |grant_i;
    assign grant_one = grant_any
                    && ((grant_i & (grant_i - Count'(1))) == '0);

    // Collapse the one-hot grant into the owner's request slice
    always_comb begin
        sel_valid = 1'b0;
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int k = 0; k < Count; k++) begin
            if (grant_i[k]) begin
                sel_valid = sel_valid | req_valid_i[k];
                sel_we    = sel_we | req_we_i[k];
                sel_addr  = sel_addr
                          | req_addr_i[k*AddrWidth +: AddrWidth];
                sel_wdata = sel_wdata
                          | req_wdata_i[k*DataWidth +: DataWidth];
            end
        end
    end

    // Next state, transaction capture and protocol checking
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        perr_d  = perr_q;

        if (tgt_rsp_valid_i && (state_q != WAIT)) begin
            perr_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (grant_one && sel_valid) begin
                    owner_d = grant_i;
                    we_d    = sel_we;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    state_d = ISSUE;
                end else if (grant_any && !grant_one) begin
                    perr_d = 1'b1;
                end
            end
            ISSUE: begin
                if (tgt_ready_i) begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (tgt_rsp_valid_i) begin
                    err_d   = 1'b0;
                    rdata_d = tgt_rdata_i;
                    state_d = RESP;
                end else if (cnt_q == CntLast) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            owner_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            perr_q  <= perr_d;
        end
    end

    // Outputs decoded from registered state only
    always_comb begin
        tgt_valid_o = (state_q == ISSUE);
        req_done_o  = '0;
        req_err_o   = '0;
        req_rdata_o = '0;
        if (state_q == RESP) begin
            req_done_o  = owner_q;
            req_err_o   = err_q ? owner_q : '0;
            req_rdata_o = rdata_q;
        end
    end

    assign tgt_we_o       = we_q;
    assign tgt_addr_o     = addr_q;
    assign tgt_wdata_o    = wdata_q;
    assign protocol_err_o = perr_q;

endmodule

// File: tb/tb_arbiter_bus_mux.sv
// tb_arbiter_bus_mux: directed and random stimulus against a
// transaction-level model of the bus mux.
module tb_arbiter_bus_mux;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int T  = 4;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic [N-1:0]    grant_i;
    logic [N-1:0]    req_valid_i;
    logic [N-1:0]    req_we_i;
    logic [N*AW-1:0] req_addr_i;
    logic [N*DW-1:0] req_wdata_i;
    logic [N-1:0]    req_done_o;
    logic [N-1:0]    req_err_o;
    logic [DW-1:0]   req_rdata_o;
    logic            tgt_valid_o;
    logic            tgt_ready_i;
    logic            tgt_we_o;
    logic [AW-1:0]   tgt_addr_o;
    logic [DW-1:0]   tgt_wdata_o;
    logic            tgt_rsp_valid_i;
    logic [DW-1:0]   tgt_rdata_i;
    logic            protocol_err_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    arbiter_bus_mux #(
        .Count(N), .AddrWidth(AW), .DataWidth(DW), .TimeoutCycles(T)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .grant_i(grant_i),
        .req_valid_i(req_valid_i), .req_we_i(req_we_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .req_done_o(req_done_o), .req_err_o(req_err_o),
        .req_rdata_o(req_rdata_o), .tgt_valid_o(tgt_valid_o),
        .tgt_ready_i(tgt_ready_i), .tgt_we_o(tgt_we_o),
        .tgt_addr_o(tgt_addr_o), .tgt_wdata_o(tgt_wdata_o),
        .tgt_rsp_valid_i(tgt_rsp_valid_i), .tgt_rdata_i(tgt_rdata_i),
        .protocol_err_o(protocol_err_o)
    );

    // Reference model: one outstanding transaction at most.
    // m_act: a requester owns the bus; m_acc: target accepted it;
    // m_waited: cycles spent waiting; m_done: completion cycle.
    bit            m_init = 0;
    bit            m_act, m_acc, m_done, m_err, m_perr;
    int            m_owner, m_waited;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;

    always @(posedge clk_i) begin
        if (!rst_ni) begin
            m_init = 1; m_act = 0; m_acc = 0; m_done = 0;
            m_err = 0; m_perr = 0; m_owner = 0; m_waited = 0;
            m_we = 0; m_addr = '0; m_wdata = '0; m_rdata = '0;
        end else if (m_init) begin
            if (tgt_rsp_valid_i && !(m_act && m_acc && !m_done))
                m_perr = 1;
            if (m_done) begin
                m_done = 0;
                m_act  = 0;
            end else if (!m_act) begin
                if ($countones(grant_i) == 1) begin
                    for (int k = 0; k < N; k++) begin
                        if (grant_i[k] && req_valid_i[k]) begin
                            m_act = 1; m_acc = 0; m_owner = k;
                            m_we    = req_we_i[k];
                            m_addr  = req_addr_i[k*AW +: AW];
                            m_wdata = req_wdata_i[k*DW +: DW];
                        end
                    end
                end else if ($countones(grant_i) > 1) begin
                    m_perr = 1;
                end
            end else if (!m_acc) begin
                if (tgt_ready_i) begin
                    m_acc = 1;
                    m_waited = 0;
                end
            end else begin
                if (tgt_rsp_valid_i) begin
                    m_done = 1; m_err = 0; m_rdata = tgt_rdata_i;
                end else begin
                    m_waited++;
                    if (m_waited == T) begin
                        m_done = 1; m_err = 1; m_rdata = '0;
                    end
                end
            end
        end
    end

    task automatic check(input string name,
                         input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_req(input int k, input bit v, input bit we,
                           input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        req_valid_i[k] = v;
        req_we_i[k] = we;
        req_addr_i[k*AW +: AW] = a;
        req_wdata_i[k*DW +: DW] = d;
    endtask

    task automatic wait_done(input string name, input int max,
                             input bit xwe, input logic [AW-1:0] xa,
                             input logic [DW-1:0] xd,
                             output int cyc, output int lastv,
                             output int vcnt, output int vbad,
                             output logic [N-1:0] d,
                             output logic [N-1:0] e,
                             output logic [DW-1:0] r);
        cyc = 0; lastv = 0; vcnt = 0; vbad = 0;
        d = '0; e = '0; r = '0;
        while (cyc < max && d == '0) begin
            @(negedge clk_i);
            cyc++;
            if (tgt_valid_o) begin
                vcnt++;
                lastv = cyc;
                if (tgt_we_o !== xwe || tgt_addr_o !== xa
                    || tgt_wdata_o !== xd)
                    vbad++;
            end
            if (req_done_o != '0) begin
                d = req_done_o; e = req_err_o; r = req_rdata_o;
            end
        end
        check({name, "_seen"}, 64'(d != '0), 64'd1);
    endtask

    // Target behaviour knobs
    int            ready_pct = 100;
    int            stall = 0;
    int            rsp_delay = 0;
    int            cd = -1;
    bit            rand_mode = 0;
    bit            inject = 0;
    bit            acc, rst_seen, done_seen;
    logic [DW-1:0] rsp_data = '0;

    int            cyc, lastv, vcnt, vbad, vsum;
    logic [N-1:0]  d, e;
    logic [DW-1:0] r;

    initial begin
        rst_ni = 0; grant_i = '0; req_valid_i = '0; req_we_i = '0;
        req_addr_i = '0; req_wdata_i = '0;
        tgt_ready_i = 0; tgt_rsp_valid_i = 0; tgt_rdata_i = '0;

        fork
            // Target: accepts per ready_pct/stall, answers after cd
            forever begin
                @(negedge clk_i);
                acc       = rst_ni && tgt_valid_o && tgt_ready_i;
                rst_seen  = !rst_ni;
                done_seen = (req_done_o != '0);
                @(posedge clk_i);
                #2;
                tgt_rsp_valid_i = 0;
                tgt_rdata_i = '0;
                if (rst_seen || done_seen) cd = -1;
                if (acc && !rst_seen)
                    cd = rand_mode ? int'($urandom_range(0, 5)) : rsp_delay;
                if (cd == 0) begin
                    tgt_rsp_valid_i = 1;
                    tgt_rdata_i = rand_mode ? DW'($urandom) : rsp_data;
                    cd = -1;
                end else if (cd > 0) begin
                    cd--;
                end
                if (inject || (rand_mode && $urandom_range(0, 99) < 2)) begin
                    tgt_rsp_valid_i = 1;
                    tgt_rdata_i = DW'($urandom);
                end
                inject = 0;
                if (tgt_valid_o && stall > 0) begin
                    tgt_ready_i = 0;
                    stall--;
                end else begin
                    tgt_ready_i = ($urandom_range(0, 99) < ready_pct);
                end
            end
            // Every-cycle comparison against the model
            forever begin
                @(negedge clk_i);
                if (m_init) begin
                    check("tgt_valid", 64'(tgt_valid_o),
                          64'(m_act && !m_acc && !m_done));
                    check("tgt_we", 64'(tgt_we_o), 64'(m_we));
                    check("tgt_addr", 64'(tgt_addr_o), 64'(m_addr));
                    check("tgt_wdata", 64'(tgt_wdata_o), 64'(m_wdata));
                    check("req_done", 64'(req_done_o),
                          m_done ? (64'd1 << m_owner) : 64'd0);
                    check("req_err", 64'(req_err_o),
                          (m_done && m_err) ? (64'd1 << m_owner) : 64'd0);
                    check("req_rdata", 64'(req_rdata_o),
                          m_done ? 64'(m_rdata) : 64'd0);
                    check("protocol_err", 64'(protocol_err_o),
                          64'(m_perr));
                end
            end
        join_none

        tick(); tick();
        rst_ni = 1;
        @(negedge clk_i);
        check("rst_done", 64'(req_done_o), 64'd0);
        check("rst_tvalid", 64'(tgt_valid_o), 64'd0);
        check("rst_perr", 64'(protocol_err_o), 64'd0);
        check("rst_addr", 64'(tgt_addr_o), 64'd0);

        // Read from requester 0
        tick();
        rsp_delay = 1; rsp_data = 32'hCAFE;
        set_req(0, 1, 0, 32'h10, 32'h0); grant_i = 3'b001;
        wait_done("t1", 20, 0, 32'h10, 32'h0,
                  cyc, lastv, vcnt, vbad, d, e, r);
        check("t1_done", 64'(d), 64'b001);
        check("t1_rdata", 64'(r), 64'hCAFE);
        check("t1_err", 64'(e), 64'd0);
        check("t1_vcnt", 64'(vcnt), 64'd1);
        tick();
        req_valid_i = '0; grant_i = '0;

        // Write from requester 1 with target stalling
        tick();
        rsp_delay = 0; stall = 3;
        set_req(1, 1, 1, 32'h20, 32'h55); grant_i = 3'b010;
        wait_done("t2", 30, 1, 32'h20, 32'h55,
                  cyc, lastv, vcnt, vbad, d, e, r);
        check("t2_done", 64'(d), 64'b010);
        check("t2_vcnt", 64'(vcnt), 64'd4);
        check("t2_stable", 64'(vbad), 64'd0);
        check("t2_err", 64'(e), 64'd0);
        tick();
        req_valid_i = '0; grant_i = '0;

        // Timeout, then response on the last wait cycle
        tick();
        rsp_delay = 99;
        set_req(2, 1, 0, 32'h30, 32'h0); grant_i = 3'b100;
        wait_done("t3a", 30, 0, 32'h30, 32'h0,
                  cyc, lastv, vcnt, vbad, d, e, r);
        check("t3a_done", 64'(d), 64'b100);
        check("t3a_err", 64'(e), 64'b100);
        check("t3a_rdata", 64'(r), 64'd0);
        check("t3a_gap", 64'(cyc - lastv), 64'd5);
        tick();
        req_valid_i = '0; grant_i = '0;
        tick();
        rsp_delay = 3; rsp_data = 32'hBEEF;
        set_req(2, 1, 0, 32'h34, 32'h0); grant_i = 3'b100;
        wait_done("t3b", 30, 0, 32'h34, 32'h0,
                  cyc, lastv, vcnt, vbad, d, e, r);
        check("t3b_done", 64'(d), 64'b100);
        check("t3b_err", 64'(e), 64'd0);
        check("t3b_rdata", 64'(r), 64'hBEEF);
        check("t3b_gap", 64'(cyc - lastv), 64'd5);
        tick();
        req_valid_i = '0; grant_i = '0;

        // Grant moves away during WAIT
        tick();
        rsp_delay = 2; rsp_data = 32'h1234;
        set_req(1, 1, 0, 32'h40, 32'h0); grant_i = 3'b010;
        tick(); tick();
        set_req(0, 1, 0, 32'h50, 32'h0); grant_i = 3'b001;
        wait_done("t4a", 20, 0, 32'h40, 32'h0,
                  cyc, lastv, vcnt, vbad, d, e, r);
        check("t4a_done", 64'(d), 64'b010);
        tick();
        req_valid_i[1] = 0;
        wait_done("t4b", 20, 0, 32'h50, 32'h0,
                  cyc, lastv, vcnt, vbad, d, e, r);
        check("t4b_done", 64'(d), 64'b001);
        check("t4b_addr", 64'(vbad), 64'd0);
        tick();
        req_valid_i = '0; grant_i = '0;

        // Multi-hot grant and stray response
        tick();
        set_req(0, 1, 0, 32'h60, 32'h0);
        set_req(1, 1, 0, 32'h64, 32'h0);
        grant_i = 3'b011;
        vsum = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            vsum += int'(tgt_valid_o);
        end
        check("t5_noissue", 64'(vsum), 64'd0);
        check("t5_perr", 64'(protocol_err_o), 64'd1);
        tick();
        rst_ni = 0; req_valid_i = '0; grant_i = '0;
        tick();
        rst_ni = 1;
        @(negedge clk_i);
        check("t5_perr_clr", 64'(protocol_err_o), 64'd0);
        tick();
        inject = 1;
        tick();
        @(negedge clk_i);
        check("t5_stray_perr", 64'(protocol_err_o), 64'd1);
        check("t5_stray_noiss", 64'(tgt_valid_o), 64'd0);
        tick();
        rst_ni = 0;
        tick();
        rst_ni = 1;

        // Reset while waiting, then a fresh request
        tick();
        rsp_delay = 99;
        set_req(0, 1, 0, 32'h70, 32'h0); grant_i = 3'b001;
        tick(); tick(); tick();
        rst_ni = 0; req_valid_i = '0; grant_i = '0;
        tick();
        rst_ni = 1;
        @(negedge clk_i);
        check("t6_tvalid", 64'(tgt_valid_o), 64'd0);
        check("t6_done", 64'(req_done_o), 64'd0);
        check("t6_addr", 64'(tgt_addr_o), 64'd0);
        tick();
        rsp_delay = 0; rsp_data = 32'h77;
        set_req(0, 1, 0, 32'h74, 32'h0); grant_i = 3'b001;
        wait_done("t6", 20, 0, 32'h74, 32'h0,
                  cyc, lastv, vcnt, vbad, d, e, r);
        check("t6_fresh_done", 64'(d), 64'b001);
        check("t6_fresh_rdata", 64'(r), 64'h77);
        tick();
        req_valid_i = '0; grant_i = '0;

        // Random traffic
        tick();
        rand_mode = 1; ready_pct = 70;
        for (int i = 0; i < 3000; i++) begin
            int p;
            p = int'($urandom_range(0, 99));
            if (p < 80) begin
                grant_i = N'(1 << $urandom_range(0, N - 1));
            end else if (p < 98) begin
                grant_i = '0;
            end else begin
                case ($urandom_range(0, 3))
                    0: grant_i = 3'b011;
                    1: grant_i = 3'b101;
                    2: grant_i = 3'b110;
                    default: grant_i = 3'b111;
                endcase
            end
            req_valid_i = N'($urandom);
            req_we_i    = N'($urandom);
            req_addr_i  = {$urandom, $urandom, $urandom};
            req_wdata_i = {$urandom, $urandom, $urandom};
            rst_ni      = ($urandom_range(0, 99) != 0);
            tick();
        end
        rst_ni = 1;
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule
